// File: rtl/gb_instr_issuer.sv
// gb_instr_issuer: buffers instructions in a FIFO and issues them to gbprocessor one at a time.
// Define GB_ISSUER_STATS_EN to add the issued_count and stall_count outputs.
module gb_instr_issuer #(
    parameter int DEPTH     = 8,
    parameter int PROBE_LAT = 4,
    parameter int IW        = 8,
    parameter int PW        = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    output logic [IW-1:0] instruction,
    output logic          valid,
    input  logic [PW-1:0] probe,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [IW-1:0] res_instr,
    output logic [PW-1:0] res_probe,
    output logic          busy
`ifdef GB_ISSUER_STATS_EN
    ,
    output logic [15:0]   issued_count,
    output logic [15:0]   stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (PROBE_LAT > 1) ? $clog2(PROBE_LAT) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAT_INIT = CW'(PROBE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_REPORT
    } state_t;

    state_t        state;
    logic [CW-1:0] lat_cnt;

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          push;
    logic          pop;
    logic          empty;
    logic [IW-1:0] head;

    // Acceptance depends only on registered occupancy, never on a same-cycle pop.
    assign in_ready = (count != FULL_CNT);
    assign empty    = (count == '0);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && !empty;
    assign head     = mem[rd_ptr];
    assign busy     = (state != S_IDLE) || !empty;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers wrap naturally at DEPTH; occupancy is tracked separately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue, latency wait, probe capture and result handshake sequencing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            valid       <= 1'b0;
            instruction <= '0;
            res_valid   <= 1'b0;
            res_instr   <= '0;
            res_probe   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        instruction <= head;
                        res_instr   <= head;
                        valid       <= 1'b1;
                        lat_cnt     <= LAT_INIT;
                        state       <= S_ISSUE;
                    end else begin
                        valid <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    valid <= 1'b0;
                    if (lat_cnt == '0) begin
                        res_probe <= probe;
                        res_valid <= 1'b1;
                        state     <= S_REPORT;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        res_probe <= probe;
                        res_valid <= 1'b1;
                        state     <= S_REPORT;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GB_ISSUER_STATS_EN
    // Issue counter wraps; stall counter saturates while a result is refused.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_count <= '0;
            stall_count  <= '0;
        end else begin
            if (pop) begin
                issued_count <= issued_count + 16'd1;
            end
            if ((state == S_REPORT) && !res_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not present in this build.
`endif

endmodule

// File: tb/tb_gb_instr_issuer.sv
// tb_gb_instr_issuer: randomized scoreboard bench for gb_instr_issuer.
// A transaction-level model predicts issues and results; a monitor checks them.
`timescale 1ns/1ps
module tb_gb_instr_issuer;

    localparam int DEPTH     = 8;
    localparam int PROBE_LAT = 4;
    localparam int IW        = 8;
    localparam int PW        = 8;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          res_ready = 1'b0;
    logic [IW-1:0] in_data   = '0;
    logic [PW-1:0] probe     = '0;
    logic          in_ready;
    logic          valid;
    logic          res_valid;
    logic          busy;
    logic [IW-1:0] instruction;
    logic [IW-1:0] res_instr;
    logic [PW-1:0] res_probe;
`ifdef GB_ISSUER_STATS_EN
    logic [15:0]   issued_count;
    logic [15:0]   stall_count;
`endif

    gb_instr_issuer #(
        .DEPTH(DEPTH),
        .PROBE_LAT(PROBE_LAT),
        .IW(IW),
        .PW(PW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .instruction(instruction),
        .valid(valid),
        .probe(probe),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_instr(res_instr),
        .res_probe(res_probe),
        .busy(busy)
`ifdef GB_ISSUER_STATS_EN
        ,
        .issued_count(issued_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IW-1:0] i;
        logic [PW-1:0] p;
        int            e;
    } rec_t;

    logic [IW-1:0] m_q[$];
    rec_t          iss_q[$];
    rec_t          res_q[$];
    int            cyc        = 0;
    bit            m_active   = 0;
    bit            m_reported = 0;
    bit            last_acc   = 0;
    bit            push_ok    = 0;
    logic [IW-1:0] m_instr    = '0;
    int            m_sample   = 0;
    logic [15:0]   m_issued   = '0;
    logic [15:0]   m_stall    = '0;

    int n_vec = 0;
    int n_bad = 0;
    bit rand_probe = 1;
    bit rand_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one in-flight instruction at a time, results sampled
    // PROBE_LAT edges after issue, next issue only after the result is taken.
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_q.delete();
            iss_q.delete();
            res_q.delete();
            m_active   = 0;
            m_reported = 0;
            last_acc   = 0;
            m_issued   = '0;
            m_stall    = '0;
        end else begin
            push_ok = in_valid && (m_q.size() < DEPTH);
            if (m_active && m_reported) begin
                if (res_ready) m_active = 0;
                else if (m_stall != 16'hFFFF) m_stall++;
            end else if (m_active) begin
                if (cyc == m_sample) begin
                    res_q.push_back('{i: m_instr, p: probe, e: cyc});
                    m_reported = 1;
                end
            end else if (m_q.size() != 0) begin
                m_instr    = m_q.pop_front();
                m_active   = 1;
                m_reported = 0;
                m_sample   = cyc + PROBE_LAT;
                iss_q.push_back('{i: m_instr, p: '0, e: cyc});
                m_issued++;
            end
            if (push_ok) m_q.push_back(in_data);
            last_acc = push_ok;
        end
    end

    logic [IW-1:0] last_instr = '0;
    bit            have_cur   = 0;
    bit            exp_v;
    bit            exp_r;
    rec_t          cur;

    // Monitor: compare DUT outputs on the falling edge against model queues.
    always @(negedge clock) begin
        if (reset) begin
            have_cur   = 0;
            last_instr = '0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
            chk("busy", 32'(busy), 32'(m_active || (m_q.size() != 0)));
            exp_v = (iss_q.size() != 0) && (iss_q[0].e == cyc);
            chk("valid", 32'(valid), 32'(exp_v));
            if (exp_v) begin
                last_instr = iss_q[0].i;
                void'(iss_q.pop_front());
            end
            chk("instruction", 32'(instruction), 32'(last_instr));
            exp_r = (res_q.size() != 0) && (res_q[0].e == cyc);
            if (have_cur) begin
                chk("res_valid_hold", 32'(res_valid), 32'd1);
                chk("res_instr_hold", 32'(res_instr), 32'(cur.i));
                chk("res_probe_hold", 32'(res_probe), 32'(cur.p));
            end else begin
                chk("res_valid", 32'(res_valid), 32'(exp_r));
                if (exp_r) begin
                    cur      = res_q.pop_front();
                    have_cur = 1;
                    chk("res_instr", 32'(res_instr), 32'(cur.i));
                    chk("res_probe", 32'(res_probe), 32'(cur.p));
                end
            end
            if (have_cur && res_ready) have_cur = 0;
`ifdef GB_ISSUER_STATS_EN
            chk("issued_count", 32'(issued_count), 32'(m_issued));
            chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rand_probe) probe = PW'($urandom);
        if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_one(input logic [IW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            step();
            n++;
        end while (!last_acc && n < 200);
        n_vec++;
        if (!last_acc) begin
            n_bad++;
            $display("FAIL push_timeout: data %0h not accepted after 200 cycles, expected acceptance", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((m_active || m_q.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        n_vec++;
        if (m_active || m_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", maxc);
        end
        step();
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_instruction"}, 32'(instruction), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_instr"}, 32'(res_instr), 32'd0);
        chk({tag, "_res_probe"}, 32'(res_probe), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset, then idle with no pushes.
        reset = 1'b1;
        step();
        step();
        chk_reset_outputs("rst");
        reset = 1'b0;
        repeat (20) step();

        // Single instruction with a fixed probe value.
        rand_probe = 0;
        probe      = 8'h3C;
        res_ready  = 1'b1;
        push_one(8'h80);
        wait_idle(50);
        rand_probe = 1;

        // Fill to full under backpressure, refuse one more, then drain in order.
        res_ready = 1'b0;
        for (int k = 1; k <= 9; k++) push_one(IW'(k));
        in_valid = 1'b1;
        in_data  = 8'h0A;
        repeat (3) step();
        in_valid = 1'b0;
        repeat (10) step();
        res_ready = 1'b1;
        wait_idle(300);

        // Reset while waiting on probe with three entries still queued.
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) push_one(IW'(8'h21 + k));
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        step();
        reset = 1'b0;
        repeat (15) step();
        push_one(8'h55);
        wait_idle(50);

        // Pointer wrap-around with bursty pushes and random backpressure.
        rand_ready = 1;
        for (int k = 0; k < 20; k++) begin
            push_one(IW'(8'h10 + k));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) step();
        end
        rand_ready = 0;
        res_ready  = 1'b1;
        wait_idle(400);

        // Fully random traffic.
        rand_ready = 1;
        repeat (400) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = IW'($urandom);
            step();
        end
        in_valid   = 1'b0;
        rand_ready = 0;
        res_ready  = 1'b1;
        wait_idle(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
